// File: rtl/cpu6_exmemwb_pkg.sv
// cpu6_exmemwb_pkg: shared cpu6 widths, register-zero index and the
// per-instruction control bundle carried from EX into MEM.
package cpu6_exmemwb_pkg;
  localparam int CPU6_XLEN = 32;
  localparam int CPU6_RFIDX_W = 5;
  localparam int CPU6_REG_ZERO = 0;
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
    logic jump;
  } ctrl_t;
endpackage

// File: rtl/cpu6_fwdunit.sv
// cpu6_fwdunit: MEM/WB operand forwarding for both EX sources plus load-use
// detection; purely combinational.
module cpu6_fwdunit
  import cpu6_exmemwb_pkg::*;
#(
  parameter int XLEN = CPU6_XLEN,
  parameter int RFIDX_W = CPU6_RFIDX_W
) (
  input  logic [RFIDX_W-1:0] rs1_i,
  input  logic [RFIDX_W-1:0] rs2_i,
  input  logic [XLEN-1:0]    rs1data_i,
  input  logic [XLEN-1:0]    rs2data_i,
  input  logic               valid_m_i,
  input  logic               regwrite_m_i,
  input  logic               memtoreg_m_i,
  input  logic [RFIDX_W-1:0] wreg_m_i,
  input  logic [XLEN-1:0]    res_m_i,
  input  logic               rf_we_i,
  input  logic [RFIDX_W-1:0] rf_waddr_i,
  input  logic [XLEN-1:0]    rf_wdata_i,
  output logic [XLEN-1:0]    fwd1_o,
  output logic [XLEN-1:0]    fwd2_o,
  output logic               loaduse_o
);
  localparam logic [RFIDX_W-1:0] ZERO = RFIDX_W'(CPU6_REG_ZERO);
  logic m_hit;
  logic m_load;
  // A load in MEM has no data yet, so it never forwards; loaduse covers it.
  function automatic logic [XLEN-1:0] pick(
    input logic [RFIDX_W-1:0] idx,
    input logic [XLEN-1:0]    rd,
    input logic               mh,
    input logic [RFIDX_W-1:0] wm,
    input logic [XLEN-1:0]    rm,
    input logic               we,
    input logic [RFIDX_W-1:0] wa,
    input logic [XLEN-1:0]    wd
  );
    return idx == ZERO ? '0 : (mh && wm == idx) ? rm : (we && wa == idx) ? wd : rd;
  endfunction
  assign m_hit = valid_m_i & regwrite_m_i & ~memtoreg_m_i;
  assign m_load = valid_m_i & memtoreg_m_i & regwrite_m_i & (wreg_m_i != ZERO);
  assign fwd1_o = pick(rs1_i, rs1data_i, m_hit, wreg_m_i, res_m_i, rf_we_i, rf_waddr_i, rf_wdata_i);
  assign fwd2_o = pick(rs2_i, rs2data_i, m_hit, wreg_m_i, res_m_i, rf_we_i, rf_waddr_i, rf_wdata_i);
  assign loaduse_o = m_load & (wreg_m_i == rs1_i | wreg_m_i == rs2_i);
endmodule

// File: rtl/cpu6_exmemwb.sv
// cpu6_exmemwb: MEM and WB stages of the cpu6 pipeline with forwarding,
// load-use interlock and a wait-state data-memory port with timeout.
module cpu6_exmemwb
  import cpu6_exmemwb_pkg::*;
#(
  parameter int XLEN = CPU6_XLEN,
  parameter int RFIDX_W = CPU6_RFIDX_W,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               validE,
  input  logic               flushE,
  input  logic [RFIDX_W-1:0] rs1E,
  input  logic [RFIDX_W-1:0] rs2E,
  input  logic [XLEN-1:0]    rs1dataE,
  input  logic [XLEN-1:0]    rs2dataE,
  output logic [XLEN-1:0]    fwdrs1E,
  output logic [XLEN-1:0]    fwdrs2E,
  input  logic [XLEN-1:0]    aluoutE,
  input  logic [XLEN-1:0]    pcplus4E,
  input  logic [RFIDX_W-1:0] writeregE,
  input  logic               regwriteE,
  input  logic               memtoregE,
  input  logic               memwriteE,
  input  logic               jumpE,
  output logic               stallE,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_ack,
  output logic               bus_err,
  output logic               rf_we,
  output logic [RFIDX_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [RFIDX_W-1:0] ZERO = RFIDX_W'(CPU6_REG_ZERO);
  ctrl_t              ctrl_e;
  ctrl_t              ctrl_m_q;
  logic               valid_m_q, valid_m_d;
  logic [XLEN-1:0]    alu_m_q, wdata_m_q, pc4_m_q, res_m;
  logic [RFIDX_W-1:0] wreg_m_q;
  logic               valid_w_q, valid_w_d;
  logic               err_w_q, regwrite_w_q, memtoreg_w_q, jump_w_q;
  logic [XLEN-1:0]    rdata_w_q, alu_w_q, pc4_w_q;
  logic [RFIDX_W-1:0] wreg_w_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               memop_m, timeout_m, adv_m, loaduse, take_e;

  cpu6_fwdunit #(.XLEN(XLEN), .RFIDX_W(RFIDX_W)) u_fwd (
    .rs1_i       (rs1E),
    .rs2_i       (rs2E),
    .rs1data_i   (rs1dataE),
    .rs2data_i   (rs2dataE),
    .valid_m_i   (valid_m_q),
    .regwrite_m_i(ctrl_m_q.regwrite),
    .memtoreg_m_i(ctrl_m_q.memtoreg),
    .wreg_m_i    (wreg_m_q),
    .res_m_i     (res_m),
    .rf_we_i     (rf_we),
    .rf_waddr_i  (rf_waddr),
    .rf_wdata_i  (rf_wdata),
    .fwd1_o      (fwdrs1E),
    .fwd2_o      (fwdrs2E),
    .loaduse_o   (loaduse)
  );

  assign ctrl_e = {regwriteE, memtoregE, memwriteE, jumpE};
  assign memop_m = valid_m_q & (ctrl_m_q.memtoreg | ctrl_m_q.memwrite);
  assign timeout_m = (cnt_q == CW'(TIMEOUT - 1)) & memop_m & ~dmem_ack;
  assign adv_m = ~memop_m | dmem_ack | timeout_m;
  assign take_e = validE & ~flushE & ~loaduse;
  assign stallE = validE & ~flushE & (~adv_m | loaduse);
  assign res_m = ctrl_m_q.jump ? pc4_m_q : alu_m_q;

  assign dmem_req = memop_m;
  assign dmem_we = ctrl_m_q.memwrite;
  assign dmem_addr = alu_m_q;
  assign dmem_wdata = wdata_m_q;

  assign rf_wdata = memtoreg_w_q ? rdata_w_q : (jump_w_q ? pc4_w_q : alu_w_q);
  assign rf_we = valid_w_q & regwrite_w_q & ~err_w_q & (wreg_w_q != ZERO);
  assign rf_waddr = wreg_w_q;
  assign bus_err = valid_w_q & err_w_q;

  // While MEM waits, WB keeps its contents but is invalidated so it retires once.
  always_comb begin
    valid_m_d = adv_m ? take_e : valid_m_q;
    valid_w_d = adv_m & valid_m_q;
    cnt_d = adv_m ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_m_q <= 1'b0;
      ctrl_m_q <= '0;
      alu_m_q <= '0;
      wdata_m_q <= '0;
      pc4_m_q <= '0;
      wreg_m_q <= '0;
      valid_w_q <= 1'b0;
      err_w_q <= 1'b0;
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
      jump_w_q <= 1'b0;
      rdata_w_q <= '0;
      alu_w_q <= '0;
      pc4_w_q <= '0;
      wreg_w_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_m_q <= valid_m_d;
      valid_w_q <= valid_w_d;
      cnt_q <= cnt_d;
      if (adv_m) begin
        err_w_q <= timeout_m;
        regwrite_w_q <= ctrl_m_q.regwrite;
        memtoreg_w_q <= ctrl_m_q.memtoreg;
        jump_w_q <= ctrl_m_q.jump;
        rdata_w_q <= dmem_rdata;
        alu_w_q <= alu_m_q;
        pc4_w_q <= pc4_m_q;
        wreg_w_q <= wreg_m_q;
      end
      if (adv_m && take_e) begin
        ctrl_m_q <= ctrl_e;
        alu_m_q <= aluoutE;
        wdata_m_q <= fwdrs2E;
        pc4_m_q <= pcplus4E;
        wreg_m_q <= writeregE;
      end
    end
  end
endmodule
